osd_batch_enqueuer: RTL and testbench
=====================================

# osd_batch_enqueuer

Command store and sequencer between the OSD init/programming FSM and the OSD command executor. Loads up to NUM_CMDS_MAX `osd_cmd_pkg::osd_cmd_t` entries through a write port. On `start` it replays entries 0..count-1, in order, over a valid/ready stream to the downstream OSD writer. It signals completion with a one-cycle `done` pulse.

## Interface
- NUM_CMDS_MAX, 64, store depth in commands; ≥2. AW = $clog2(NUM_CMDS_MAX), CW = $clog2(NUM_CMDS_MAX+1).
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_we  in  1  write strobe into store
- load_addr  in  AW  store write address
- load_data  in  osd_cmd_t  command to store
- seq_count  in  CW  number of commands to replay, sampled with `start`
- start  in  1  begin replay (level or pulse; sampled in IDLE only)
- busy  out  1  replay in progress
- done  out  1  one-cycle completion pulse
- cmd_valid  out  1  command available downstream
- cmd_ready  in  1  downstream accepts
- cmd_data  out  osd_cmd_t  current command
- cmd_last  out  1  qualifies final command of batch (valid only with cmd_valid)
- abort  in  1  only with OSD_ENQ_ABORT_EN; stop replay early

## Operation
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - `load_we` writes `load_data` to `store[load_addr]`.
  - On `start`, latch the count as min(seq_count, NUM_CMDS_MAX) and clear the index.
  - Go to DONE if the latched count is 0, else to FETCH.
- FETCH: synchronous read of `store[idx]` into the `cmd_data` register; next state PRESENT.
- PRESENT:
  - `cmd_valid`=1.
  - `cmd_last` = (idx == cnt-1).
  - `cmd_data` is held stable until handshake.
  - On `cmd_valid && cmd_ready`: go to DONE if last, else idx+1 and go to FETCH.
- DONE: `done`=1 for one cycle; next state IDLE.
- `busy` = state ∈ {FETCH, PRESENT}. `busy` is 0 in DONE.
- `load_we` outside IDLE is ignored; the store is frozen during replay.
- `start` outside IDLE is ignored.
- `load_we` and `start` in the same IDLE cycle: both take effect. The write lands before the FETCH read, so the new data is visible.
- idx is AW+1 bits internally with no wrap. idx never exceeds cnt-1.
- Unwritten entries replay whatever the store holds; no validity tracking.

## Timing
- Reset values: state IDLE; busy, done, cmd_valid, cmd_last = 0; cmd_data = '0; idx, cnt = 0. Store contents are not reset.
- `start` sampled at edge 0:
  - FETCH in cycle 1.
  - cmd_valid=1 with cmd[0] in cycle 2.
- Throughput is one command per 2 cycles when `cmd_ready` is held high. The bubble is the FETCH cycle.
- Last handshake at edge c → done=1 in cycle c+1 → IDLE in cycle c+2.
- count=0: done=1 in cycle 1, with no cmd_valid.
- `cmd_valid` never drops without a handshake, except on abort or reset.
- `rst_n` low mid-replay: all outputs drop immediately to their reset values, and no done pulse is emitted.

## Configuration
- OSD_ENQ_ABORT_EN defined:
  - The `abort` port exists.
  - `abort` in FETCH → DONE next cycle.
  - `abort` in PRESENT with a handshake in the same cycle: the command counts as sent, then DONE.
  - `abort` in PRESENT without a handshake: cmd_valid drops next cycle, then DONE.
  - `done` still pulses once. `abort` in IDLE/DONE is ignored.
- Not defined: no `abort` port; replay always runs to cnt.

## Structure
- `osd_cmd_t` stays in `osd_cmd_pkg`.
- Add `OSD_ENQ_STATE_W` and the enqueuer `state_t` enum to `osd_cmd_pkg` so the producer FSM and benches can decode debug state.
- Sub-module `osd_cmd_store`: simple dual-port RAM with one write port and one registered read port, NUM_CMDS_MAX × $bits(osd_cmd_t), no reset on the array.

## Test plan
- Load 3 commands A,B,C at 0..2; start with seq_count=3 and cmd_ready=1 → A in cycle 2, B in 4, C in 6 with cmd_last=1; done in cycle 7; busy high in cycles 1–6.
- seq_count=0 → done=1 in cycle 1, cmd_valid never asserts, busy stays 0.
- Hold cmd_ready=0 for 5 cycles on B → cmd_data=B stable and cmd_valid high throughout; resume → C follows 2 cycles after the B handshake.
- seq_count=NUM_CMDS_MAX+1 (65) → exactly 64 commands emitted, cmd_last on entry 63; load_we during busy leaves the store unchanged (verified by a second replay).
- Assert rst_n low in PRESENT on the 2nd command → cmd_valid, busy = 0 immediately, no done pulse; a new start afterwards replays from entry 0.
- OSD_ENQ_ABORT_EN: abort in PRESENT of cmd 1 with cmd_ready=0 → cmd_valid=0 next cycle, done pulse, total handshakes = 1.

Source files
------------

// File: rtl/osd_cmd_pkg.sv
// Shared OSD command types plus the batch enqueuer state encoding,
// so the producer FSM and benches can decode the enqueuer debug state.
package osd_cmd_pkg;

    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] reg_addr;
        logic [31:0] wdata;
    } osd_cmd_t;

    localparam int OSD_ENQ_STATE_W = 2;

    typedef enum logic [OSD_ENQ_STATE_W-1:0] {
        ENQ_IDLE    = 2'd0,
        ENQ_FETCH   = 2'd1,
        ENQ_PRESENT = 2'd2,
        ENQ_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/osd_cmd_store.sv
// Command store: simple dual-port RAM, one write port, one registered
// read port. The array itself is not reset; only the read register is.
import osd_cmd_pkg::*;

module osd_cmd_store #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  osd_cmd_t        wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output osd_cmd_t        rdata
);

    osd_cmd_t mem [DEPTH];
    osd_cmd_t rdata_q;
    osd_cmd_t rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/osd_batch_enqueuer.sv
// Replays a loaded batch of OSD commands over a valid/ready stream.
// Optional early stop via the abort port when OSD_ENQ_ABORT_EN is defined.
import osd_cmd_pkg::*;

module osd_batch_enqueuer #(
    parameter  int NUM_CMDS_MAX = 64,
    localparam int AW = $clog2(NUM_CMDS_MAX),
    localparam int CW = $clog2(NUM_CMDS_MAX + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_we,
    input  logic [AW-1:0]   load_addr,
    input  osd_cmd_t        load_data,
    input  logic [CW-1:0]   seq_count,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output osd_cmd_t        cmd_data,
    output logic            cmd_last
`ifdef OSD_ENQ_ABORT_EN
    ,
    input  logic            abort
`endif
);

    state_t          state_q, state_d;
    logic [AW:0]     idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_clamp;
    logic            abort_w;
    logic            last_w;
    logic            hs_w;
    logic            wr_w;
    logic            rd_w;

`ifdef OSD_ENQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign cnt_clamp = (seq_count > CW'(NUM_CMDS_MAX))
                     ? CW'(NUM_CMDS_MAX) : seq_count;

    // idx stays below cnt, so it always fits in the count width
    assign last_w = (CW'(idx_q) == (cnt_q - CW'(1)));
    assign hs_w   = (state_q == ENQ_PRESENT) && cmd_ready;
    assign wr_w   = load_we && (state_q == ENQ_IDLE);
    assign rd_w   = (state_q == ENQ_FETCH);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ENQ_IDLE: begin
                if (start) begin
                    cnt_d   = cnt_clamp;
                    idx_d   = '0;
                    state_d = (cnt_clamp == '0) ? ENQ_DONE : ENQ_FETCH;
                end
            end
            ENQ_FETCH: begin
                state_d = abort_w ? ENQ_DONE : ENQ_PRESENT;
            end
            ENQ_PRESENT: begin
                if (hs_w && !last_w) begin
                    idx_d   = idx_q + {{AW{1'b0}}, 1'b1};
                    state_d = abort_w ? ENQ_DONE : ENQ_FETCH;
                end else if (hs_w || abort_w) begin
                    state_d = ENQ_DONE;
                end
            end
            ENQ_DONE: begin
                state_d = ENQ_IDLE;
            end
            default: begin
                state_d = ENQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENQ_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    osd_cmd_store #(
        .DEPTH (NUM_CMDS_MAX)
    ) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_w),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (rd_w),
        .raddr (idx_q[AW-1:0]),
        .rdata (cmd_data)
    );

    assign busy      = (state_q == ENQ_FETCH) || (state_q == ENQ_PRESENT);
    assign done      = (state_q == ENQ_DONE);
    assign cmd_valid = (state_q == ENQ_PRESENT);
    assign cmd_last  = (state_q == ENQ_PRESENT) && last_w;

endmodule

// File: tb/tb_osd_batch_enqueuer.sv
// Bench for osd_batch_enqueuer: random commands against a store model.
import osd_cmd_pkg::*;

module tb_osd_batch_enqueuer;

    localparam int N = 64;

    logic           clk;
    logic           rst_n;
    logic           load_we;
    logic [5:0]     load_addr;
    osd_cmd_t       load_data;
    logic [6:0]     seq_count;
    logic           start;
    logic           busy;
    logic           done;
    logic           cmd_valid;
    logic           cmd_ready;
    osd_cmd_t       cmd_data;
    logic           cmd_last;
`ifdef OSD_ENQ_ABORT_EN
    logic           abort;
`endif

    int total;
    int bad;
    osd_cmd_t model [N];

    osd_batch_enqueuer #(.NUM_CMDS_MAX(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .seq_count (seq_count),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_last  (cmd_last)
`ifdef OSD_ENQ_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic osd_cmd_t rand_cmd();
        logic [63:0] r;
        osd_cmd_t c;
        r = {$urandom, $urandom};
        c = r[47:0];
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] a, input osd_cmd_t d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_we   = 1'b0;
        model[a]  = d;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = '0;
        seq_count = '0;
        start     = 1'b0;
        cmd_ready = 1'b0;
`ifdef OSD_ENQ_ABORT_EN
        abort     = 1'b0;
`endif
        step();
        step();
        total++;
        if ({busy, done, cmd_valid, cmd_last} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, cmd_valid, cmd_last});
        end
        total++;
        if (cmd_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", cmd_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        osd_cmd_t a;
        logic exp_v;
        int k;
        a = rand_cmd();
        load(6'd1, rand_cmd());
        load(6'd2, rand_cmd());
        // write of entry 0 lands in the same cycle as start
        load_we   = 1'b1;
        load_addr = 6'd0;
        load_data = a;
        model[0]  = a;
        seq_count = 7'd3;
        start     = 1'b1;
        cmd_ready = 1'b1;
        step();
        load_we = 1'b0;
        start   = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            exp_v = (cyc == 2) || (cyc == 4) || (cyc == 6);
            total++;
            if (busy !== (cyc <= 6)) begin
                bad++;
                $display("FAIL basic_busy c%0d: got %b want %b", cyc, busy, cyc <= 6);
            end
            total++;
            if (cmd_valid !== exp_v) begin
                bad++;
                $display("FAIL basic_valid c%0d: got %b want %b", cyc, cmd_valid, exp_v);
            end
            if (exp_v) begin
                k = (cyc - 2) / 2;
                total++;
                if (cmd_data !== model[k]) begin
                    bad++;
                    $display("FAIL basic_data c%0d: got %h want %h", cyc, cmd_data, model[k]);
                end
                total++;
                if (cmd_last !== (cyc == 6)) begin
                    bad++;
                    $display("FAIL basic_last c%0d: got %b want %b", cyc, cmd_last, cyc == 6);
                end
            end
            total++;
            if (done !== (cyc == 7)) begin
                bad++;
                $display("FAIL basic_done c%0d: got %b want %b", cyc, done, cyc == 7);
            end
            step();
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_zero();
        seq_count = 7'd0;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            total++;
            if (done !== (cyc == 1)) begin
                bad++;
                $display("FAIL zero_done c%0d: got %b want %b", cyc, done, cyc == 1);
            end
            total++;
            if ({busy, cmd_valid} !== 2'b00) begin
                bad++;
                $display("FAIL zero_idle c%0d: got %b want 00", cyc, {busy, cmd_valid});
            end
            step();
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) load(6'(i), rand_cmd());
        seq_count = 7'd3;
        start     = 1'b1;
        cmd_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        total++;
        if (cmd_valid !== 1'b1 || cmd_data !== model[0]) begin
            bad++;
            $display("FAIL stall_a: got v=%b %h want v=1 %h", cmd_valid, cmd_data, model[0]);
        end
        step();
        step();
        cmd_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (cmd_valid !== 1'b1 || cmd_data !== model[1]) begin
                bad++;
                $display("FAIL stall_hold k%0d: got v=%b %h want v=1 %h", k, cmd_valid, cmd_data, model[1]);
            end
            if (k == 5) cmd_ready = 1'b1;
            step();
        end
        total++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_bubble: got v=%b busy=%b want v=0 busy=1", cmd_valid, busy);
        end
        step();
        total++;
        if (cmd_valid !== 1'b1 || cmd_data !== model[2] || cmd_last !== 1'b1) begin
            bad++;
            $display("FAIL stall_c: got v=%b l=%b %h want v=1 l=1 %h", cmd_valid, cmd_last, cmd_data, model[2]);
        end
        step();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL stall_done: got %b want 1", done);
        end
        cmd_ready = 1'b0;
        step();
    endtask

    task automatic test_full();
        osd_cmd_t got_d [$];
        logic     got_l [$];
        osd_cmd_t prev_d;
        logic     prev_v;
        logic     prev_hs;
        logic     seen_done;
        for (int i = 0; i < N; i++) load(6'(i), rand_cmd());
        for (int run = 0; run < 2; run++) begin
            got_d.delete();
            got_l.delete();
            prev_v    = 1'b0;
            prev_hs   = 1'b0;
            prev_d    = '0;
            seen_done = 1'b0;
            seq_count = (run == 0) ? 7'd65 : 7'd64;
            start     = 1'b1;
            step();
            start = 1'b0;
            for (int c = 0; c < 2000 && !seen_done; c++) begin
                if (prev_v && !prev_hs) begin
                    total++;
                    if (cmd_valid !== 1'b1 || cmd_data !== prev_d) begin
                        bad++;
                        $display("FAIL full_stable r%0d c%0d: got v=%b %h want v=1 %h", run, c, cmd_valid, cmd_data, prev_d);
                    end
                end
                if (done) seen_done = 1'b1;
                cmd_ready = (run == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                load_we   = (run == 0) && busy && ($urandom_range(0, 2) == 0);
                load_addr = 6'($urandom_range(0, N - 1));
                load_data = rand_cmd();
                prev_v    = cmd_valid;
                prev_d    = cmd_data;
                prev_hs   = cmd_valid && cmd_ready;
                if (prev_hs) begin
                    got_d.push_back(cmd_data);
                    got_l.push_back(cmd_last);
                end
                step();
            end
            load_we   = 1'b0;
            cmd_ready = 1'b0;
            total++;
            if (!seen_done) begin
                bad++;
                $display("FAIL full_timeout r%0d: got no done want done", run);
            end
            total++;
            if (got_d.size() != N) begin
                bad++;
                $display("FAIL full_count r%0d: got %0d want %0d", run, got_d.size(), N);
            end
            for (int i = 0; i < got_d.size() && i < N; i++) begin
                total++;
                if (got_d[i] !== model[i] || got_l[i] !== (i == N - 1)) begin
                    bad++;
                    $display("FAIL full_cmd r%0d i%0d: got %h l=%b want %h l=%b", run, i, got_d[i], got_l[i], model[i], i == N - 1);
                end
            end
            step();
        end
    endtask

    task automatic test_rst_mid();
        logic seen_done;
        for (int i = 0; i < 3; i++) load(6'(i), rand_cmd());
        seq_count = 7'd3;
        start     = 1'b1;
        cmd_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        total++;
        if (cmd_valid !== 1'b1 || cmd_data !== model[1]) begin
            bad++;
            $display("FAIL rst_pre: got v=%b %h want v=1 %h", cmd_valid, cmd_data, model[1]);
        end
        cmd_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({cmd_valid, busy, cmd_last, done} !== 4'b0000 || cmd_data !== '0) begin
            bad++;
            $display("FAIL rst_drop: got %b %h want 0000 0", {cmd_valid, busy, cmd_last, done}, cmd_data);
        end
        step();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (done) seen_done = 1'b1;
            step();
        end
        total++;
        if (seen_done) begin
            bad++;
            $display("FAIL rst_nodone: got done pulse want none");
        end
        seq_count = 7'd2;
        start     = 1'b1;
        cmd_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        total++;
        if (cmd_valid !== 1'b1 || cmd_data !== model[0]) begin
            bad++;
            $display("FAIL rst_restart: got v=%b %h want v=1 %h", cmd_valid, cmd_data, model[0]);
        end
        for (int k = 0; k < 10 && !done; k++) step();
        cmd_ready = 1'b0;
        step();
    endtask

`ifdef OSD_ENQ_ABORT_EN
    task automatic test_abort();
        int hs;
        int dn;
        hs = 0;
        dn = 0;
        for (int i = 0; i < 3; i++) load(6'(i), rand_cmd());
        seq_count = 7'd3;
        start     = 1'b1;
        cmd_ready = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (done) dn++;
            if (cyc == 4) begin
                cmd_ready = 1'b0;
                abort     = 1'b1;
            end else begin
                abort = 1'b0;
            end
            if (cyc == 5) begin
                total++;
                if (cmd_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_drop: got v=%b want 0", cmd_valid);
                end
            end
            if (cmd_valid && cmd_ready) hs++;
            step();
        end
        abort     = 1'b0;
        cmd_ready = 1'b0;
        total++;
        if (hs != 1) begin
            bad++;
            $display("FAIL abort_hs: got %0d want 1", hs);
        end
        total++;
        if (dn != 1) begin
            bad++;
            $display("FAIL abort_done: got %0d pulses want 1", dn);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_full();
        test_rst_mid();
`ifdef OSD_ENQ_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
